// File: rtl/pair_collector_pkg.sv
// Shared types and constants for the pair_collector operand stage.
package pair_collector_pkg;

    localparam int unsigned PC_W_DEFAULT = 11;
    localparam int unsigned PC_CNT_W     = 16;

    typedef enum logic [1:0] {
        PC_EMPTY = 2'd0,
        PC_HALF  = 2'd1,
        PC_FULL  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pair_collector.sv
// pair_collector: gathers two consecutive stream words into an operand pair
// (xa, xb) with registered reduction flags and hands it downstream over
// valid/ready. Optional pair counter enabled by PAIR_COLLECTOR_CNT_EN.
module pair_collector
    import pair_collector_pkg::*;
#(
    parameter int unsigned W = PC_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [W-1:0]        xa,
    output logic [W-1:0]        xb,
    output logic                ya,
    output logic                yb,
    output logic                out_valid,
    input  logic                out_ready
`ifdef PAIR_COLLECTOR_CNT_EN
    ,
    output logic [PC_CNT_W-1:0] pair_cnt
`endif
);

    pc_state_e    state_q, state_d;
    logic [W-1:0] xa_q, xa_d;
    logic [W-1:0] xb_q, xb_d;
    logic         ya_q, ya_d;
    logic         yb_q, yb_d;
    logic         in_xfer;
    logic         out_xfer;
    logic         load_a;
    logic         load_b;

    // Handshake outputs; in_ready only depends on out_ready while a pair is held.
    always_comb begin
        out_valid = (state_q == PC_FULL);
        in_ready  = (state_q != PC_FULL) || out_ready;
        // flush suppresses both accept and emit; the upstream word is dropped.
        in_xfer   = in_valid && in_ready && !flush;
        out_xfer  = out_valid && out_ready && !flush;
    end

    // Next-state and operand load selection.
    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        if (flush) begin
            state_d = PC_EMPTY;
        end else begin
            unique case (state_q)
                PC_EMPTY: begin
                    if (in_xfer) begin
                        load_a  = 1'b1;
                        state_d = PC_HALF;
                    end
                end
                PC_HALF: begin
                    if (in_xfer) begin
                        load_b  = 1'b1;
                        state_d = PC_FULL;
                    end
                end
                PC_FULL: begin
                    if (out_xfer && in_xfer) begin
                        load_a  = 1'b1;
                        state_d = PC_HALF;
                    end else if (out_xfer) begin
                        state_d = PC_EMPTY;
                    end
                end
                default: state_d = PC_EMPTY;
            endcase
        end
    end

    // Operand and flag capture; flags come from the word being captured.
    always_comb begin
        xa_d = load_a ? in_data : xa_q;
        ya_d = load_a ? (&in_data) : ya_q;
        xb_d = load_b ? in_data : xb_q;
        yb_d = load_b ? ~(&in_data) : yb_q;
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PC_EMPTY;
            xa_q    <= '0;
            xb_q    <= '0;
            ya_q    <= 1'b0;
            yb_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            ya_q    <= ya_d;
            yb_q    <= yb_d;
        end
    end

    assign xa = xa_q;
    assign xb = xb_q;
    assign ya = ya_q;
    assign yb = yb_q;

`ifdef PAIR_COLLECTOR_CNT_EN
    logic [PC_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of emitted pairs; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && (cnt_q != {PC_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pair_cnt = cnt_q;
`endif

endmodule
